// File: rtl/dsp_gemm_tile_sequencer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : dsp_gemm_tile_sequencer
// Purpose  : Runs GEMM tiles one at a time through the DSP cascade datapath.
//            Streams K_DEPTH A/B operand reads per tile, produces the aligned
//            mux_A/mux_B data-valid strobes, predicts the cascade result
//            (DSP_op_data_valid) and commits each tile to the PS-side BRAM.
// Ports    : clk, rst_n           - clock, async active-low reset
//            start, abort         - run request / synchronous cancel
//            num_tiles            - tiles to run (captured with start)
//            busy, done, tile_cnt - run status to the PS control registers
//            a_/b_rd_en, a_/b_rd_addr          - operand BRAM reads
//            mux_A/mux_B_data_valid            - DSP data controller strobes
//            DSP_op_data_valid                 - cascade result valid
//            ps_bram_we, ps_bram_addr          - result BRAM write
// Revision : 1.0 - initial release
// ============================================================================
module dsp_gemm_tile_sequencer #(
    parameter int NUM_CASCADE_CHAINS = 32,
    parameter int K_DEPTH            = 32,
    parameter int ADDR_W             = 10,
    parameter int RD_LAT             = 2,
    parameter int OP_LAT             = 40,
    parameter int WR_LAT             = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              abort,
    input  logic [15:0]       num_tiles,
    output logic              busy,
    output logic              done,
    output logic [15:0]       tile_cnt,
    output logic              a_rd_en,
    output logic [ADDR_W-1:0] a_rd_addr,
    output logic              b_rd_en,
    output logic [ADDR_W-1:0] b_rd_addr,
    output logic              mux_A_data_valid,
    output logic              mux_B_data_valid,
    output logic              DSP_op_data_valid,
    output logic              ps_bram_we,
    output logic [ADDR_W-1:0] ps_bram_addr
);

    localparam int c_K_W   = (K_DEPTH > 1) ? $clog2(K_DEPTH) : 1;
    localparam int c_LAT_W = $clog2(OP_LAT + WR_LAT + 1);

    generate
        if (K_DEPTH < 1 || RD_LAT < 1 || OP_LAT < 1 || WR_LAT < 1 ||
            NUM_CASCADE_CHAINS < 1) begin : g_bad_params
            $error("dsp_gemm_tile_sequencer: invalid parameter value");
        end
    endgenerate

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FEED  = 2'd1,
        S_DRAIN = 2'd2,
        S_FIN   = 2'd3
    } state_t;

    state_t              r_state;
    logic [15:0]         r_num_tiles;
    logic [15:0]         r_tile_cnt;
    logic [c_K_W-1:0]    r_k;
    logic [ADDR_W-1:0]   r_rd_addr;
    logic                r_rd_en;
    logic                r_done;
    logic [RD_LAT-1:0]   r_rd_sr;
    logic [c_LAT_W-1:0]  r_lat;
    logic                r_op_valid;
    logic                r_we;
    logic [ADDR_W-1:0]   r_ps_addr;

    logic [RD_LAT:0]     w_chain;
    logic                w_mux_last;
    logic                w_op_fire;
    logic                w_we_fire;
    logic                w_last_tile;

    // w_chain[0] is the read enable itself, w_chain[i] is it delayed i cycles.
    assign w_chain    = {r_rd_sr, r_rd_en};
    // Last mux valid of a tile: valid now, and nothing follows next cycle.
    assign w_mux_last = w_chain[RD_LAT] & ~w_chain[RD_LAT-1];

    // r_lat counts cycles since the last mux valid (1 = first cycle after it).
    // A registered output fires one cycle after its condition, hence the -1.
    assign w_op_fire  = (OP_LAT == 1) ? w_mux_last
                                      : (r_lat == c_LAT_W'(OP_LAT - 1));
    assign w_we_fire  = (r_lat == c_LAT_W'(OP_LAT + WR_LAT - 1));

    assign w_last_tile = (({1'b0, r_tile_cnt} + 17'd1) == {1'b0, r_num_tiles});

    // Control FSM: state, read stream and completion.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_num_tiles <= '0;
            r_tile_cnt  <= '0;
            r_k         <= '0;
            r_rd_addr   <= '0;
            r_rd_en     <= 1'b0;
            r_done      <= 1'b0;
        end else if (abort) begin
            // Cancel wins over everything, including a same-cycle start.
            r_state <= S_IDLE;
            r_k     <= '0;
            r_rd_en <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_done <= 1'b0;
                    if (start) begin
                        r_num_tiles <= num_tiles;
                        r_tile_cnt  <= '0;
                        r_k         <= '0;
                        r_rd_addr   <= '0;
                        if (num_tiles == 16'd0) begin
                            r_state <= S_FIN;
                            r_done  <= 1'b1;
                        end else begin
                            r_state <= S_FEED;
                            r_rd_en <= 1'b1;
                        end
                    end
                end
                S_FEED: begin
                    // Tiles are contiguous, so the address simply keeps
                    // counting across tiles (tile*K_DEPTH + k, wrapping).
                    r_rd_addr <= r_rd_addr + ADDR_W'(1);
                    if (r_k == c_K_W'(K_DEPTH - 1)) begin
                        r_k     <= '0;
                        r_rd_en <= 1'b0;
                        r_state <= S_DRAIN;
                    end else begin
                        r_k <= r_k + c_K_W'(1);
                    end
                end
                S_DRAIN: begin
                    if (r_we) begin
                        if (w_last_tile) begin
                            r_state <= S_FIN;
                            r_done  <= 1'b1;
                        end else begin
                            r_tile_cnt <= r_tile_cnt + 16'd1;
                            r_state    <= S_FEED;
                            r_rd_en    <= 1'b1;
                        end
                    end
                end
                default: begin
                    r_done  <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    // Delay lines: read-to-mux shift register and saturating result timer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rd_sr    <= '0;
            r_lat      <= '0;
            r_op_valid <= 1'b0;
            r_we       <= 1'b0;
            r_ps_addr  <= '0;
        end else if (abort) begin
            r_rd_sr    <= '0;
            r_lat      <= '0;
            r_op_valid <= 1'b0;
            r_we       <= 1'b0;
        end else begin
            r_rd_sr    <= w_chain[RD_LAT-1:0];
            r_op_valid <= w_op_fire;
            r_we       <= w_we_fire;
            if (w_we_fire) begin
                r_ps_addr <= ADDR_W'(r_tile_cnt);
            end
            if (w_mux_last) begin
                r_lat <= c_LAT_W'(1);
            end else if (w_we_fire) begin
                r_lat <= '0;
            end else if (r_lat != '0 && r_lat != {c_LAT_W{1'b1}}) begin
                r_lat <= r_lat + c_LAT_W'(1);
            end
        end
    end

    assign busy              = (r_state != S_IDLE);
    assign done              = r_done;
    assign tile_cnt          = r_tile_cnt;
    assign a_rd_en           = r_rd_en;
    assign b_rd_en           = r_rd_en;
    assign a_rd_addr         = r_rd_addr;
    assign b_rd_addr         = r_rd_addr;
    assign mux_A_data_valid  = w_chain[RD_LAT];
    assign mux_B_data_valid  = w_chain[RD_LAT];
    assign DSP_op_data_valid = r_op_valid;
    assign ps_bram_we        = r_we;
    assign ps_bram_addr      = r_ps_addr;

endmodule
`default_nettype wire

// File: tb/tb_dsp_gemm_tile_sequencer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_dsp_gemm_tile_sequencer
// Purpose  : Directed self-checking bench. Expected read/valid/write/done
//            events are queued from a timing model when a run is started and
//            popped as the DUTs produce them. A second instance with a 5-bit
//            address width runs the same stimulus to cover address wrap.
// Revision : 1.0 - initial release
// ============================================================================
module tb_dsp_gemm_tile_sequencer;

    localparam int K  = 32;
    localparam int RD = 2;
    localparam int OP = 40;
    localparam int WR = 4;
    localparam int AW = 10;
    localparam int P  = K + RD + OP + WR;   // per-tile period

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic          abort = 1'b0;
    logic [15:0]   num_tiles = '0;

    logic          busy, done, a_rd_en, b_rd_en, mux_a, mux_b, dsp_v, we;
    logic [15:0]   tile_cnt;
    logic [AW-1:0] a_addr, b_addr, ps_addr;

    logic          busy5, done5, a_rd_en5, b_rd_en5, mux_a5, mux_b5, dsp_v5, we5;
    logic [15:0]   tile_cnt5;
    logic [4:0]    a_addr5, b_addr5, ps_addr5;

    dsp_gemm_tile_sequencer #(
        .NUM_CASCADE_CHAINS(32), .K_DEPTH(K), .ADDR_W(AW),
        .RD_LAT(RD), .OP_LAT(OP), .WR_LAT(WR)
    ) u_dut (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
        .num_tiles(num_tiles), .busy(busy), .done(done), .tile_cnt(tile_cnt),
        .a_rd_en(a_rd_en), .a_rd_addr(a_addr), .b_rd_en(b_rd_en), .b_rd_addr(b_addr),
        .mux_A_data_valid(mux_a), .mux_B_data_valid(mux_b),
        .DSP_op_data_valid(dsp_v), .ps_bram_we(we), .ps_bram_addr(ps_addr)
    );

    dsp_gemm_tile_sequencer #(
        .NUM_CASCADE_CHAINS(32), .K_DEPTH(K), .ADDR_W(5),
        .RD_LAT(RD), .OP_LAT(OP), .WR_LAT(WR)
    ) u_dut5 (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
        .num_tiles(num_tiles), .busy(busy5), .done(done5), .tile_cnt(tile_cnt5),
        .a_rd_en(a_rd_en5), .a_rd_addr(a_addr5), .b_rd_en(b_rd_en5), .b_rd_addr(b_addr5),
        .mux_A_data_valid(mux_a5), .mux_B_data_valid(mux_b5),
        .DSP_op_data_valid(dsp_v5), .ps_bram_we(we5), .ps_bram_addr(ps_addr5)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc = cyc + 1;

    typedef struct {
        int cyc;
        int val;
    } ev_t;

    ev_t q_rd[$];
    ev_t q_mux[$];
    ev_t q_dsp[$];
    ev_t q_we[$];
    ev_t q_done[$];

    int errors = 0;
    int checks = 0;
    int n_we   = 0;
    bit mon_en = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // Timing model: start sampled in cycle s, first FEED cycle is s+1.
    task automatic sb_run(input int s, input int n);
        int f;
        for (int t = 0; t < n; t++) begin
            f = s + 1 + t * P;
            for (int k = 0; k < K; k++) begin
                q_rd.push_back('{f + k, t * K + k});
                q_mux.push_back('{f + RD + k, 0});
            end
            q_dsp.push_back('{f + K - 1 + RD + OP, 0});
            q_we.push_back('{f + K - 1 + RD + OP + WR, t});
        end
        q_done.push_back('{(n == 0) ? s + 1 : s + 1 + n * P, 0});
    endtask

    // Cancel/reset: nothing expected after the given cycle survives.
    task automatic sb_flush(input int after);
        for (int i = q_rd.size() - 1; i >= 0; i--)   if (q_rd[i].cyc > after)   q_rd.delete(i);
        for (int i = q_mux.size() - 1; i >= 0; i--)  if (q_mux[i].cyc > after)  q_mux.delete(i);
        for (int i = q_dsp.size() - 1; i >= 0; i--)  if (q_dsp[i].cyc > after)  q_dsp.delete(i);
        for (int i = q_we.size() - 1; i >= 0; i--)   if (q_we[i].cyc > after)   q_we.delete(i);
        for (int i = q_done.size() - 1; i >= 0; i--) if (q_done[i].cyc > after) q_done.delete(i);
    endtask

    task automatic check_drained();
        chk("left_rd",   q_rd.size(),   0);
        chk("left_mux",  q_mux.size(),  0);
        chk("left_dsp",  q_dsp.size(),  0);
        chk("left_we",   q_we.size(),   0);
        chk("left_done", q_done.size(), 0);
    endtask

    task automatic chk_busy(input string tag, input logic exp);
        chk(tag, busy, exp);
        chk({tag, "_w5"}, busy5, exp);
    endtask

    task automatic wait_cyc(input int t);
        while (cyc < t) @(negedge clk);
    endtask

    task automatic do_start(input int n, output int s);
        start     = 1'b1;
        num_tiles = 16'(n);
        s         = cyc;
        sb_run(s, n);
        @(negedge clk);
        start = 1'b0;
    endtask

    // Output monitor / scoreboard consumer.
    always @(negedge clk) begin
        ev_t e;
        if (mon_en) begin
            if (a_rd_en || b_rd_en) begin
                if (q_rd.size() == 0) chk("rd_spurious", 1, 0);
                else begin
                    e = q_rd.pop_front();
                    chk("rd_cycle", cyc, e.cyc);
                    chk("rd_en_pair", {a_rd_en, b_rd_en, a_rd_en5, b_rd_en5}, 4'hF);
                    chk("a_rd_addr", a_addr, e.val % 1024);
                    chk("b_rd_addr", b_addr, e.val % 1024);
                    chk("a_rd_addr_w5", a_addr5, e.val % 32);
                    chk("b_rd_addr_w5", b_addr5, e.val % 32);
                end
            end
            if (mux_a || mux_b) begin
                if (q_mux.size() == 0) chk("mux_spurious", 1, 0);
                else begin
                    e = q_mux.pop_front();
                    chk("mux_cycle", cyc, e.cyc);
                    chk("mux_pair", {mux_a, mux_b, mux_a5, mux_b5}, 4'hF);
                end
            end
            if (dsp_v) begin
                if (q_dsp.size() == 0) chk("dsp_spurious", 1, 0);
                else begin
                    e = q_dsp.pop_front();
                    chk("dsp_cycle", cyc, e.cyc);
                    chk("dsp_w5", dsp_v5, 1);
                end
            end
            if (we) begin
                n_we++;
                if (q_we.size() == 0) chk("we_spurious", 1, 0);
                else begin
                    e = q_we.pop_front();
                    chk("we_cycle", cyc, e.cyc);
                    chk("ps_bram_addr", ps_addr, e.val % 1024);
                    chk("ps_bram_addr_w5", ps_addr5, e.val % 32);
                    chk("we_w5", we5, 1);
                end
            end
            if (done) begin
                if (q_done.size() == 0) chk("done_spurious", 1, 0);
                else begin
                    e = q_done.pop_front();
                    chk("done_cycle", cyc, e.cyc);
                    chk("done_w5", done5, 1);
                end
            end
        end
    end

    initial begin
        int s;
        int we0;

        // Reset state
        repeat (3) @(negedge clk);
        chk_busy("rst_busy", 1'b0);
        chk("rst_done", done, 0);
        chk("rst_tile_cnt", tile_cnt, 0);
        chk("rst_rd_en", {a_rd_en, b_rd_en}, 0);
        chk("rst_rd_addr", a_addr, 0);
        chk("rst_mux", {mux_a, mux_b}, 0);
        chk("rst_dsp", dsp_v, 0);
        chk("rst_we", we, 0);
        chk("rst_ps_addr", ps_addr, 0);
        rst_n  = 1'b1;
        mon_en = 1'b1;
        @(negedge clk);

        // One tile
        chk_busy("t1_busy_before", 1'b0);
        do_start(1, s);
        chk_busy("t1_busy_first", 1'b1);
        wait_cyc(s + 1 + P);
        chk_busy("t1_busy_last", 1'b1);
        wait_cyc(s + 2 + P);
        chk_busy("t1_busy_after", 1'b0);
        wait_cyc(s + P + 8);
        check_drained();
        chk("t1_tile_cnt", tile_cnt, 0);

        // Two tiles (second tile wraps in the 5-bit instance)
        we0 = n_we;
        do_start(2, s);
        wait_cyc(s + 2 * P + 8);
        chk("t2_we_count", n_we - we0, 2);
        chk("t2_tile_cnt", tile_cnt, 1);
        chk("t2_tile_cnt_w5", tile_cnt5, 1);
        chk_busy("t2_busy_after", 1'b0);
        check_drained();

        // Zero tiles
        do_start(0, s);
        chk_busy("t0_busy", 1'b1);
        @(negedge clk);
        chk_busy("t0_busy_after", 1'b0);
        repeat (10) @(negedge clk);
        check_drained();

        // start and abort together in IDLE: nothing happens
        start = 1'b1; abort = 1'b1; num_tiles = 16'd1;
        @(negedge clk);
        start = 1'b0; abort = 1'b0;
        chk_busy("sa_busy", 1'b0);
        repeat (10) @(negedge clk);
        check_drained();

        // Abort mid-run
        do_start(3, s);
        wait_cyc(s + 50);
        abort = 1'b1;
        sb_flush(s + 50);
        @(negedge clk);
        abort = 1'b0;
        chk_busy("ab_busy", 1'b0);
        chk("ab_tile_cnt", tile_cnt, 0);
        wait_cyc(s + 3 * P + 8);
        chk("ab_tile_cnt_held", tile_cnt, 0);
        check_drained();

        // Start while busy, then async reset mid-run, then a fresh run
        do_start(2, s);
        wait_cyc(s + 20);
        start = 1'b1; num_tiles = 16'd5;
        @(negedge clk);
        start = 1'b0;
        wait_cyc(s + 40);
        #2 rst_n = 1'b0;
        sb_flush(s + 40);
        #1;
        chk_busy("rs_busy", 1'b0);
        chk("rs_done", done, 0);
        chk("rs_rd_en", {a_rd_en, b_rd_en}, 0);
        chk("rs_rd_addr", a_addr, 0);
        chk("rs_mux", {mux_a, mux_b}, 0);
        chk("rs_dsp", dsp_v, 0);
        chk("rs_we", we, 0);
        chk("rs_tile_cnt", tile_cnt, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check_drained();
        do_start(1, s);
        chk_busy("rs2_busy", 1'b1);
        wait_cyc(s + P + 8);
        chk_busy("rs2_busy_after", 1'b0);
        chk("rs2_tile_cnt", tile_cnt, 0);
        check_drained();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
